uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Hardware replacement for the soft-core housekeeping loop.
- Parses the single-character UART command stream and sequences the 8-bit port bus (port_id / out_port / write_strobe / read_strobe / in_port) that feeds the GPIO port bank.
- Read results go back over the UART transmitter.
- Sits between the UART rx/tx cores and the existing port decode/mux logic; drives the bus exactly like the CPU core does.

Parameters:
- HEX_REPLY, 0, 0: 'r' returns one raw byte. 1: 'r' returns two uppercase ASCII hex characters, MS nibble first.
- AUTO_INC, 0, 1: port_id increments (mod 256) after each completed 'w' or 'r'.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid while rx_ready=1
- rx_ready  in  1  rx holds an unread byte
- rx_read  out  1  one-cycle pulse consuming rx_data
- tx_data  out  8  byte to send, stable from tx_write until tx_ready falls
- tx_ready  in  1  transmitter idle
- tx_write  out  1  one-cycle pulse starting transmission
- port_id  out  8  current port address
- out_port  out  8  write data
- write_strobe  out  1  one-cycle write pulse
- read_strobe  out  1  one-cycle read pulse
- in_port  in  8  combinational read data for port_id
- busy  out  1  high in any state other than IDLE
- err_count  out  8  saturating count of unrecognised characters

Behaviour:
- Reset (async assert, sync deassert): every output 0; state IDLE; internal accumulator acc = 0.
- Character classes:
  - '0'-'9' -> value c-0x30.
  - 'A'-'F' / 'a'-'f' -> 10..15.
  - 'm', 'w', 'r' are commands.
  - CR, LF and space are ignored silently.
  - Anything else: err_count += 1 (saturates at 255); acc is unchanged.
- Nibble: acc <= {acc[3:0], value}. Only the last two digits matter.
- FSM states: IDLE, RX_ACK, EXEC, TX_WAIT, TX_ACK.
- IDLE, rx_ready=1:
  - pulse rx_read for one cycle;
  - latch rx_data;
  - classify and apply in the same cycle;
  - go to RX_ACK.
- RX_ACK: wait for rx_ready=0 so the same byte is never consumed twice. Then:
  - 'w' or 'r' pending -> EXEC;
  - otherwise -> IDLE.
- 'm': port_id <= acc, applied at classification.
- EXEC 'w':
  - out_port <= acc and write_strobe=1 in the same registered cycle, with port_id stable;
  - then AUTO_INC update;
  - -> IDLE.
- EXEC 'r':
  - read_strobe=1 for one cycle; in_port is captured into rd_byte on that cycle;
  - next cycle AUTO_INC update;
  - -> TX_WAIT.
- TX_WAIT:
  - wait for tx_ready=1;
  - drive tx_data (raw byte, or the next hex char when HEX_REPLY=1) and pulse tx_write;
  - -> TX_ACK.
- TX_ACK:
  - wait for tx_ready=0;
  - if a second hex char remains -> TX_WAIT, otherwise -> IDLE.
- tx_data holds its value until the next load.
- Latency from rx_read:
  - 'w' strobe fires 2 cycles after rx_ready falls;
  - 'r' tx_write fires no earlier than 3 cycles after rx_ready falls.
- While busy, new rx bytes are left pending in the rx core; no byte is dropped by this block.
- port_id, out_port and acc persist across commands; only reset clears them.
- AUTO_INC wraps 255 -> 0.
- Reset mid-transaction aborts immediately: strobes and pulses drop asynchronously; any partial hex reply is abandoned.

Decomposition:
- Shared package cmd_pkg:
  - character constants (CMD_M, CMD_W, CMD_R, CR, LF, SP);
  - FSM state enum;
  - function hex_val(char) -> {valid, nibble};
  - function nib2ascii(nibble) -> uppercase ASCII.
- One natural sub-module: uart_byte_handshake. It implements the pulse-then-wait-for-ready-deassert protocol and is instantiated twice, once for rx_read/rx_ready and once for tx_write/tx_ready.

Test Plan:
- Send "1", "2", "m", "A", "5", "w" -> port_id=0x12; one write_strobe pulse with out_port=0xA5; no tx_write; busy returns low.
- Send "3", "m", "r" with in_port model returning 0x5C for port 0x03 -> one read_strobe with port_id=0x03; tx_write once with tx_data=0x5C. Repeat with HEX_REPLY=1 -> tx_data '5' (0x35) then 'C' (0x43), two pulses.
- AUTO_INC=1: "F", "F", "m", "0", "0", "w", "w" -> writes land on port_id 0xFF then 0x00 (wrap); port_id ends at 0x01.
- Send "x", "!", CR, "g", then 255 more "x" -> err_count goes 1, 2, 2, 3, then saturates at 255; acc unchanged; no strobes.
- Hold tx_ready low 50 cycles during 'r', and keep rx_ready high with the next byte queued -> no rx_read until tx completes; byte consumed exactly once afterwards.
- Assert reset_n low one cycle after read_strobe during 'r' -> all outputs 0 asynchronously; after release, FSM in IDLE; no tx_write emitted.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the UART command sequencer: character codes, FSM states
// and the character/nibble conversion helpers.
package cmd_pkg;

  localparam logic [7:0] CMD_M = 8'h6d;
  localparam logic [7:0] CMD_W = 8'h77;
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CR    = 8'h0d;
  localparam logic [7:0] LF    = 8'h0a;
  localparam logic [7:0] SP    = 8'h20;

  typedef enum logic [2:0] {
    StIdle,
    StRxAck,
    StExec,
    StTxWait,
    StTxAck
  } state_e;

  typedef enum logic [1:0] {
    CmdNone,
    CmdWrite,
    CmdRead
  } cmd_e;

  // Returns {valid, nibble}; valid is 0 for anything that is not a hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h37 + {4'h0, n};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// One-cycle request pulse followed by a wait for the peer to drop its ready flag.
// done marks the cycle in which the peer has acknowledged the pulse.
module uart_byte_handshake (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic ready,
  output logic pulse,
  output logic done
);

  logic pulse_q;
  logic wait_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      pulse_q <= start;
      if (start) begin
        wait_q <= 1'b1;
      end else if (done) begin
        wait_q <= 1'b0;
      end
    end
  end

  // Ignore ready during the pulse cycle itself; the peer reacts on the following edge.
  assign done  = wait_q && !pulse_q && !ready;
  assign pulse = pulse_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses single-character UART commands and sequences the 8-bit port bus
// (m = set port, w = write, r = read and reply over the UART transmitter).
module uart_cmd_sequencer
  import cmd_pkg::*;
#(
  parameter bit HEX_REPLY = 1'b0,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_read,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       tx_write,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       busy,
  output logic [7:0] err_count
);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] port_id_q, port_id_d;
  logic [7:0] out_port_q, out_port_d;
  logic       write_strobe_q, write_strobe_d;
  logic       read_strobe_q, read_strobe_d;
  logic [7:0] err_q, err_d;
  logic [7:0] rd_byte_q, rd_byte_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_second_q, tx_second_d;

  logic       rx_start, rx_done;
  logic       tx_start, tx_done;
  logic [4:0] hv;

  assign hv = hex_val(rx_data);

  uart_byte_handshake u_rx_hs (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (rx_start),
    .ready   (rx_ready),
    .pulse   (rx_read),
    .done    (rx_done)
  );

  uart_byte_handshake u_tx_hs (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tx_start),
    .ready   (tx_ready),
    .pulse   (tx_write),
    .done    (tx_done)
  );

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    acc_d          = acc_q;
    port_id_d      = port_id_q;
    out_port_d     = out_port_q;
    write_strobe_d = 1'b0;
    read_strobe_d  = 1'b0;
    err_d          = err_q;
    rd_byte_d      = rd_byte_q;
    tx_data_d      = tx_data_q;
    tx_second_d    = tx_second_q;
    rx_start       = 1'b0;
    tx_start       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_ready) begin
          rx_start = 1'b1;
          cmd_d    = CmdNone;
          state_d  = StRxAck;
          if (hv[4]) begin
            acc_d = {acc_q[3:0], hv[3:0]};
          end else if (rx_data == CMD_M) begin
            port_id_d = acc_q;
          end else if (rx_data == CMD_W) begin
            cmd_d = CmdWrite;
          end else if (rx_data == CMD_R) begin
            cmd_d = CmdRead;
          end else if (rx_data == CR || rx_data == LF || rx_data == SP) begin
            cmd_d = CmdNone;
          end else if (err_q != 8'hff) begin
            err_d = err_q + 8'd1;
          end
        end
      end

      StRxAck: begin
        if (rx_done) begin
          state_d = (cmd_q == CmdNone) ? StIdle : StExec;
        end
      end

      // First EXEC cycle raises the strobe; the second retires it, so port_id only
      // advances once the strobe has been seen with a stable address.
      StExec: begin
        if (!write_strobe_q && !read_strobe_q) begin
          if (cmd_q == CmdWrite) begin
            out_port_d     = acc_q;
            write_strobe_d = 1'b1;
          end else begin
            read_strobe_d = 1'b1;
          end
        end else begin
          if (AUTO_INC) begin
            port_id_d = port_id_q + 8'd1;
          end
          if (read_strobe_q) begin
            rd_byte_d   = in_port;
            tx_second_d = 1'b0;
            state_d     = StTxWait;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StTxWait: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = StTxAck;
          if (!HEX_REPLY) begin
            tx_data_d = rd_byte_q;
          end else if (tx_second_q) begin
            tx_data_d = nib2ascii(rd_byte_q[3:0]);
          end else begin
            tx_data_d = nib2ascii(rd_byte_q[7:4]);
          end
        end
      end

      StTxAck: begin
        if (tx_done) begin
          if (HEX_REPLY && !tx_second_q) begin
            tx_second_d = 1'b1;
            state_d     = StTxWait;
          end else begin
            tx_second_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cmd_q          <= CmdNone;
      acc_q          <= 8'h00;
      port_id_q      <= 8'h00;
      out_port_q     <= 8'h00;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      err_q          <= 8'h00;
      rd_byte_q      <= 8'h00;
      tx_data_q      <= 8'h00;
      tx_second_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      acc_q          <= acc_d;
      port_id_q      <= port_id_d;
      out_port_q     <= out_port_d;
      write_strobe_q <= write_strobe_d;
      read_strobe_q  <= read_strobe_d;
      err_q          <= err_d;
      rd_byte_q      <= rd_byte_d;
      tx_data_q      <= tx_data_d;
      tx_second_q    <= tx_second_d;
    end
  end

  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = write_strobe_q;
  assign read_strobe  = read_strobe_q;
  assign err_count    = err_q;
  assign tx_data      = tx_data_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench: two instances (raw reply + auto-increment, hex reply + fixed port)
// driven by directed and random command streams against a character-level model.
module tb_uart_cmd_sequencer;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] port;
    logic [7:0] data;
  } ev_t;

  localparam logic [1:0] EvW = 2'd0;
  localparam logic [1:0] EvR = 2'd1;
  localparam logic [1:0] EvT = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Port bank read data as a function of the address.
  function automatic logic [7:0] periph(input logic [7:0] p);
    return p * 8'd7 + 8'h47;
  endfunction

  function automatic ev_t mk_ev(input logic [1:0] k, input logic [7:0] p, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.port = p;
    e.data = d;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : env
    localparam bit Hex  = (g == 1);
    localparam bit Auto = (g == 0);

    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_write;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       busy;
    logic [7:0] err_count;

    assign in_port = periph(port_id);

    uart_cmd_sequencer #(
      .HEX_REPLY (Hex),
      .AUTO_INC  (Auto)
    ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .rx_read      (rx_read),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .tx_write     (tx_write),
      .port_id      (port_id),
      .out_port     (out_port),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .in_port      (in_port),
      .busy         (busy),
      .err_count    (err_count)
    );

    ev_t        exp_q[$];
    logic [7:0] rxq[$];
    logic [7:0] m_acc, m_port, m_out;
    int         m_err;
    int         pushed = 0;
    int         consumed = 0;
    int         last_drop = 0;
    bit         rx_drop = 1'b0;
    bit         tx_drop = 1'b0;
    bit         tx_hold = 1'b0;
    int         tx_cnt = 0;
    bit         done = 1'b0;
    string      hexs = "0123456789ABCDEF";
    string      junks = "xgGZ!@M~q";

    task automatic chk(input string n, input int a, input int e);
      check($sformatf("env%0d_%s", g, n), a, e);
    endtask

    // Reference model: applies one character's effect and queues the bus/UART events.
    task automatic model(input logic [7:0] c);
      int v;
      logic [7:0] d;
      v = -1;
      if (c >= 8'h30 && c <= 8'h39) v = int'(c) - 48;
      else if (c >= 8'h41 && c <= 8'h46) v = int'(c) - 55;
      else if (c >= 8'h61 && c <= 8'h66) v = int'(c) - 87;
      if (v >= 0) begin
        m_acc = (m_acc * 16 + v) % 256;
      end else if (c == 8'h6d) begin
        m_port = m_acc;
      end else if (c == 8'h77) begin
        m_out = m_acc;
        exp_q.push_back(mk_ev(EvW, m_port, m_acc));
        if (Auto) m_port = m_port + 8'd1;
      end else if (c == 8'h72) begin
        d = periph(m_port);
        exp_q.push_back(mk_ev(EvR, m_port, 8'h00));
        if (Hex) begin
          exp_q.push_back(mk_ev(EvT, 8'h00, hexs[d / 16]));
          exp_q.push_back(mk_ev(EvT, 8'h00, hexs[d % 16]));
        end else begin
          exp_q.push_back(mk_ev(EvT, 8'h00, d));
        end
        if (Auto) m_port = m_port + 8'd1;
      end else if (c == 8'h0d || c == 8'h0a || c == 8'h20) begin
        m_err = m_err;
      end else if (m_err < 255) begin
        m_err++;
      end
    endtask

    task automatic send_byte(input logic [7:0] c);
      model(c);
      rxq.push_back(c);
      pushed++;
    endtask

    task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
      int stable = 0;
      int n = 0;
      while (stable < 2 && n < 3000) begin
        @(posedge clk);
        #2;
        n++;
        if (rxq.size() == 0 && !rx_ready && !rx_drop && !busy && tx_ready && !tx_drop)
          stable++;
        else
          stable = 0;
      end
      chk("settle_in_time", int'(stable >= 2), 1);
    endtask

    task automatic check_state();
      chk("port_id", port_id, m_port);
      chk("out_port", out_port, m_out);
      chk("err_count", err_count, m_err);
      chk("busy_idle", busy, 0);
    endtask

    task automatic wait_rd(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(posedge clk);
        #2;
        if (read_strobe) begin
          seen = 1'b1;
          break;
        end
      end
    endtask

    function automatic logic [7:0] rand_char();
      int r;
      logic [7:0] c;
      int n;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        n = $urandom_range(0, 15);
        c = hexs[n];
        if (n > 9 && $urandom_range(0, 1) == 1) c = c | 8'h20;
      end else if (r < 50) c = 8'h77;
      else if (r < 58) c = 8'h72;
      else if (r < 66) c = 8'h6d;
      else if (r < 70) c = 8'h20;
      else if (r < 72) c = 8'h0d;
      else if (r < 74) c = 8'h0a;
      else c = junks[$urandom_range(0, junks.len() - 1)];
      return c;
    endfunction

    // UART receiver core: presents queued bytes, drops rx_ready the edge after rx_read.
    initial begin
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      forever begin
        @(posedge clk);
        #1;
        if (rx_read) begin
          chk("rx_single_consume", int'(rx_drop || !rx_ready), 0);
          consumed++;
        end
        if (rx_drop) begin
          rx_ready  = 1'b0;
          rx_drop   = 1'b0;
          last_drop = cyc;
        end else if (!rx_ready && rxq.size() > 0) begin
          rx_data  = rxq.pop_front();
          rx_ready = 1'b1;
        end
        if (rx_read) rx_drop = 1'b1;
      end
    end

    // UART transmitter core: busy for a random few cycles after each tx_write.
    initial begin
      bit start;
      tx_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        start = tx_write;
        if (start) chk("tx_write_accept", int'(tx_ready && !tx_drop), 1);
        if (tx_drop) begin
          tx_ready = 1'b0;
          tx_drop  = 1'b0;
          tx_cnt   = $urandom_range(0, 3);
        end else if (tx_hold) begin
          tx_ready = 1'b0;
        end else if (!tx_ready) begin
          if (tx_cnt > 0) tx_cnt--;
          else tx_ready = 1'b1;
        end
        if (start) tx_drop = 1'b1;
      end
    end

    task automatic observe(input logic [1:0] kind, input logic [7:0] port, input logic [7:0] data);
      ev_t e;
      chk("ev_available", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ev_kind", kind, e.kind);
        if (kind != EvT) chk("ev_port", port, e.port);
        if (kind != EvR) chk("ev_data", data, e.data);
      end
      if (kind == EvW) chk("w_latency", cyc - last_drop, 2);
      if (kind == EvT) chk("r_latency_min", int'((cyc - last_drop) >= 3), 1);
    endtask

    always @(negedge clk) begin
      if (reset_n) begin
        if (write_strobe) observe(EvW, port_id, out_port);
        if (read_strobe) observe(EvR, port_id, 8'h00);
        if (tx_write) observe(EvT, 8'h00, tx_data);
      end
    end

    initial begin
      bit seen;
      int cnt;
      logic [7:0] errc[4];
      int errexp[4];
      errc = '{8'h78, 8'h21, 8'h0d, 8'h67};
      reset_n = 1'b0;
      m_acc = 8'h00;
      m_port = 8'h00;
      m_out = 8'h00;
      m_err = 0;
      repeat (3) @(negedge clk);
      chk("reset_strobes", {rx_read, tx_write, write_strobe, read_strobe, busy}, 0);
      chk("reset_port_id", port_id, 0);
      chk("reset_out_port", out_port, 0);
      chk("reset_err_count", err_count, 0);
      chk("reset_tx_data", tx_data, 0);
      @(negedge clk);
      reset_n = 1'b1;

      send("12mA5w");
      settle();
      check_state();
      send("03mr");
      settle();
      check_state();
      send("FFm00ww");
      settle();
      check_state();

      errexp = '{1, 2, 2, 3};
      for (int i = 0; i < 4; i++) begin
        send_byte(errc[i]);
        settle();
        chk("err_step", err_count, errexp[i]);
      end
      for (int i = 0; i < 255; i++) send_byte(8'h78);
      settle();
      chk("err_saturated", err_count, 255);
      check_state();
      send("m");
      settle();
      check_state();

      // Transmitter stalled while the next byte waits in the receiver.
      tx_hold = 1'b1;
      send("03mr");
      send_byte(8'h37);
      wait_rd(seen);
      chk("hold_rd_seen", seen, 1);
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk);
        #2;
        if (rx_read) cnt++;
      end
      chk("hold_no_rx_read", cnt, 0);
      chk("hold_rx_pending", rx_ready, 1);
      tx_hold = 1'b0;
      settle();
      check_state();
      chk("hold_consumed", consumed, pushed);

      // Reset one cycle after the read strobe abandons the reply.
      send("03mr");
      wait_rd(seen);
      chk("rst_rd_seen", seen, 1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_strobes", {rx_read, tx_write, write_strobe, read_strobe, busy}, 0);
      chk("rst_port_id", port_id, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_tx_data", tx_data, 0);
      m_acc = 8'h00;
      m_port = 8'h00;
      m_out = 8'h00;
      m_err = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      settle();
      check_state();

      for (int i = 0; i < 150; i++) begin
        send_byte(rand_char());
        if (i % 30 == 29) begin
          settle();
          check_state();
        end
      end
      settle();
      check_state();
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("bytes_consumed", consumed, pushed);
      done = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 90000; k++) begin
      @(posedge clk);
      if (env[0].done && env[1].done) break;
    end
    check("envs_finished", int'(env[0].done && env[1].done), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
